// File: rtl/fft_pkg.sv
// Shared types and sizing for the 8-point FFT frame sequencer.
package fft_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned N        = 8;
  localparam int unsigned CORE_LAT = 3;
  localparam int unsigned CNT_W    = $clog2(N);

  typedef enum logic [2:0] {
    LOAD,
    WRITE,
    RUN,
    CAPTURE,
    UNLOAD
  } state_t;

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } cplx_t;

endpackage

// File: rtl/fft_frame_buf.sv
// N-entry complex register file: indexed write, whole-frame load,
// flattened parallel read and an indexed read mux.
module fft_frame_buf
  import fft_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [CNT_W-1:0]    wr_idx,
  input  cplx_t               wr_data,
  input  logic                ld_en,
  input  logic [N*DATA_W-1:0] ld_real,
  input  logic [N*DATA_W-1:0] ld_imag,
  input  logic [CNT_W-1:0]    rd_idx,
  output cplx_t               rd_data_c,
  output logic [N*DATA_W-1:0] par_real,
  output logic [N*DATA_W-1:0] par_imag
);

  cplx_t mem [N];

  // Frame load takes priority over a single-entry write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(N); k++) mem[k] <= '0;
    end else if (ld_en) begin
      for (int k = 0; k < int'(N); k++) begin
        mem[k] <= '{re: ld_real[k*DATA_W +: DATA_W], im: ld_imag[k*DATA_W +: DATA_W]};
      end
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  for (genvar k = 0; k < int'(N); k++) begin : g_par
    assign par_real[k*DATA_W +: DATA_W] = mem[k].re;
    assign par_imag[k*DATA_W +: DATA_W] = mem[k].im;
  end

  assign rd_data_c = mem[rd_idx];

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer: serial load, core write/start/capture, serial unload.
// The handshake-less FFT core sits between in_buf and out_buf.
module fft_frame_ctrl
  import fft_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [DATA_W-1:0]   s_real,
  input  logic [DATA_W-1:0]   s_imag,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [DATA_W-1:0]   m_real,
  output logic [DATA_W-1:0]   m_imag,
  output logic                m_last,
  output logic                busy,
  output logic                core_write,
  output logic                core_start,
  output logic [N*DATA_W-1:0] core_in_real,
  output logic [N*DATA_W-1:0] core_in_imag,
  input  logic [N*DATA_W-1:0] core_out_real,
  input  logic [N*DATA_W-1:0] core_out_imag
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] LAST_LAT = CNT_W'(CORE_LAT - 1);

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [CNT_W-1:0] lat, lat_d;
  logic [CNT_W-1:0] idx, idx_d;

  logic  s_hs, m_hs, in_wr, out_ld;
  cplx_t s_sample, core_bin0, out_rd, m_bin_d;

  cplx_t               in_rd_unused;
  logic [N*DATA_W-1:0] out_par_real_unused;
  logic [N*DATA_W-1:0] out_par_imag_unused;

  assign s_hs      = (state == LOAD) && s_valid && s_ready;
  assign m_hs      = m_valid && m_ready;
  assign in_wr     = s_hs && !flush;
  assign out_ld    = (state == CAPTURE);
  assign s_sample  = '{re: s_real, im: s_imag};
  assign core_bin0 = '{re: core_out_real[DATA_W-1:0], im: core_out_imag[DATA_W-1:0]};

  fft_frame_buf in_buf (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (in_wr),
    .wr_idx    (cnt),
    .wr_data   (s_sample),
    .ld_en     (1'b0),
    .ld_real   ('0),
    .ld_imag   ('0),
    .rd_idx    ('0),
    .rd_data_c (in_rd_unused),
    .par_real  (core_in_real),
    .par_imag  (core_in_imag)
  );

  fft_frame_buf out_buf (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (1'b0),
    .wr_idx    ('0),
    .wr_data   ('0),
    .ld_en     (out_ld),
    .ld_real   (core_out_real),
    .ld_imag   (core_out_imag),
    .rd_idx    (idx_d),
    .rd_data_c (out_rd),
    .par_real  (out_par_real_unused),
    .par_imag  (out_par_imag_unused)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD;
      cnt   <= '0;
      lat   <= '0;
      idx   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      lat   <= lat_d;
      idx   <= idx_d;
    end
  end

  // flush beats a same-cycle handshake; counters wrap only through state changes.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    lat_d   = lat;
    idx_d   = idx;
    unique case (state)
      LOAD: begin
        if (flush) begin
          cnt_d = '0;
        end else if (s_hs) begin
          if (cnt == LAST_IDX) begin
            cnt_d   = '0;
            state_d = WRITE;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
      end
      WRITE: begin
        lat_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        if (lat == LAST_LAT) begin
          lat_d   = '0;
          state_d = CAPTURE;
        end else begin
          lat_d = lat + CNT_W'(1);
        end
      end
      CAPTURE: begin
        idx_d   = '0;
        state_d = UNLOAD;
      end
      UNLOAD: begin
        if (m_hs) begin
          if (idx == LAST_IDX) begin
            idx_d   = '0;
            state_d = LOAD;
          end else begin
            idx_d = idx + CNT_W'(1);
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // Bin 0 bypasses out_buf on the capture cycle since out_buf loads on the same edge.
  assign m_bin_d = (state == CAPTURE) ? core_bin0 : out_rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_ready    <= 1'b0;
      busy       <= 1'b0;
      core_write <= 1'b0;
      core_start <= 1'b0;
      m_valid    <= 1'b0;
      m_last     <= 1'b0;
      m_real     <= '0;
      m_imag     <= '0;
    end else begin
      s_ready    <= (state_d == LOAD);
      busy       <= (state_d != LOAD);
      core_write <= (state_d == WRITE);
      core_start <= (state_d == RUN);
      m_valid    <= (state_d == UNLOAD);
      m_last     <= (state_d == UNLOAD) && (idx_d == LAST_IDX);
      m_real     <= m_bin_d.re;
      m_imag     <= m_bin_d.im;
    end
  end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl with a latency-aware core model
// (stub adder or exact DFT) driving the core output ports.
module tb_fft_frame_ctrl;
  import fft_pkg::*;

  typedef logic [N-1:0][DATA_W-1:0] frame_t;
  typedef struct packed {
    logic   mode;
    frame_t in_re;
    frame_t in_im;
    frame_t ex_re;
    frame_t ex_im;
  } vec_t;

  logic clk = 1'b0;
  logic rst, flush, s_valid, s_ready, m_valid, m_ready, m_last, busy;
  logic core_write, core_start;
  logic [DATA_W-1:0]   s_real, s_imag, m_real, m_imag;
  logic [N*DATA_W-1:0] core_in_real, core_in_imag, core_out_real, core_out_imag;

  logic core_mode;
  int   run_cnt;
  int   tests = 0;
  int   fails = 0;
  vec_t vecs [5];

  always #5 clk = ~clk;

  fft_frame_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_real        (s_real),
    .s_imag        (s_imag),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_real        (m_real),
    .m_imag        (m_imag),
    .m_last        (m_last),
    .busy          (busy),
    .core_write    (core_write),
    .core_start    (core_start),
    .core_in_real  (core_in_real),
    .core_in_imag  (core_in_imag),
    .core_out_real (core_out_real),
    .core_out_imag (core_out_imag)
  );

  function automatic logic [15:0] rnd(input real x);
    int r;
    if (x >= 0.0) r = $rtoi(x + 0.5);
    else          r = -$rtoi(-x + 0.5);
    return 16'(r);
  endfunction

  function automatic logic [15:0] dft_bin(input logic [N*DATA_W-1:0] xr,
                                          input logic [N*DATA_W-1:0] xi,
                                          input int k, input bit want_im);
    real acc_r, acc_i, ang, a, b;
    acc_r = 0.0;
    acc_i = 0.0;
    for (int n = 0; n < 8; n++) begin
      a     = real'($signed(xr[n*16 +: 16]));
      b     = real'($signed(xi[n*16 +: 16]));
      ang   = -2.0 * 3.14159265358979 * real'(k * n) / 8.0;
      acc_r = acc_r + a * $cos(ang) - b * $sin(ang);
      acc_i = acc_i + a * $sin(ang) + b * $cos(ang);
    end
    return want_im ? rnd(acc_i) : rnd(acc_r);
  endfunction

  // Core model: outputs are garbage until core_start has been held CORE_LAT cycles.
  always @(posedge clk or posedge rst) begin
    if (rst)             run_cnt <= 0;
    else if (core_write) run_cnt <= 0;
    else if (core_start) run_cnt <= run_cnt + 1;
  end

  always_comb begin
    core_out_real = '0;
    core_out_imag = '0;
    for (int k = 0; k < 8; k++) begin
      if (run_cnt < int'(CORE_LAT)) begin
        core_out_real[k*16 +: 16] = 16'hDEAD;
        core_out_imag[k*16 +: 16] = 16'hBEEF;
      end else if (!core_mode) begin
        core_out_real[k*16 +: 16] = core_in_real[k*16 +: 16] + 16'(k);
        core_out_imag[k*16 +: 16] = core_in_imag[k*16 +: 16] - 16'(k);
      end else begin
        core_out_real[k*16 +: 16] = dft_bin(core_in_real, core_in_imag, k, 1'b0);
        core_out_imag[k*16 +: 16] = dft_bin(core_in_real, core_in_imag, k, 1'b1);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input frame_t re, input frame_t im, input int count, input bit hold);
    int budget;
    for (int k = 0; k < count; k++) begin
      s_valid = 1'b1;
      s_real  = re[k];
      s_imag  = im[k];
      budget  = 0;
      while (!s_ready && budget < 200) begin
        step();
        budget++;
      end
      if (!s_ready) begin
        check("send_timeout", 32'(s_ready), 32'd1);
        s_valid = 1'b0;
        return;
      end
      step();
    end
    if (!hold) s_valid = 1'b0;
  endtask

  // pat 0: always ready; pat 1: m_ready 1,0,0,1 repeating.
  task automatic collect_frame(input frame_t ex_re, input frame_t ex_im, input int pat,
                               input string tag);
    int   bin, cyc;
    bit   stalled;
    logic [15:0] prev_re, prev_im;
    bin = 0; cyc = 0; stalled = 0; prev_re = '0; prev_im = '0;
    while (bin < int'(N) && cyc < 400) begin
      m_ready = (pat == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      if (busy) check({tag, "_s_ready_busy"}, 32'(s_ready), 32'd0);
      if (m_valid) begin
        if (stalled) begin
          check({tag, "_stall_re"}, 32'(m_real), 32'(prev_re));
          check({tag, "_stall_im"}, 32'(m_imag), 32'(prev_im));
        end
        if (m_ready) begin
          check($sformatf("%s_re%0d", tag, bin), 32'(m_real), 32'(ex_re[bin]));
          check($sformatf("%s_im%0d", tag, bin), 32'(m_imag), 32'(ex_im[bin]));
          check($sformatf("%s_last%0d", tag, bin), 32'(m_last), 32'(bin == int'(N) - 1));
          bin++;
          stalled = 0;
        end else begin
          stalled = 1;
          prev_re = m_real;
          prev_im = m_imag;
        end
      end
      step();
      cyc++;
    end
    if (bin < int'(N)) check({tag, "_collect_timeout"}, 32'(bin), 32'(N));
    m_ready = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit saw_valid;
    for (int k = 0; k < 8; k++) begin
      vecs[0].mode = 1'b0;
      vecs[0].in_re[k] = 16'(16 * k);
      vecs[0].in_im[k] = 16'(3 * k);
      vecs[0].ex_re[k] = 16'(17 * k);
      vecs[0].ex_im[k] = 16'(2 * k);
      vecs[1].mode = 1'b1;
      vecs[1].in_re[k] = 16'd256;
      vecs[1].in_im[k] = 16'd0;
      vecs[1].ex_re[k] = (k == 0) ? 16'd2048 : 16'd0;
      vecs[1].ex_im[k] = 16'd0;
      vecs[2].mode = 1'b1;
      vecs[2].in_re[k] = (k == 0) ? 16'd256 : 16'd0;
      vecs[2].in_im[k] = 16'd0;
      vecs[2].ex_re[k] = 16'd256;
      vecs[2].ex_im[k] = 16'd0;
      vecs[3].mode = 1'b0;
      vecs[3].in_re[k] = 16'(-100 * k);
      vecs[3].in_im[k] = 16'(1000 * k + 7);
      vecs[3].ex_re[k] = 16'(-99 * k);
      vecs[3].ex_im[k] = 16'(999 * k + 7);
      vecs[4].mode = 1'b1;
      vecs[4].in_re[k] = 16'd0;
      vecs[4].in_im[k] = 16'hFF00;
      vecs[4].ex_re[k] = 16'd0;
      vecs[4].ex_im[k] = (k == 0) ? 16'hF800 : 16'd0;
    end

    rst = 1'b1; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
    s_real = '0; s_imag = '0; core_mode = 1'b0;
    #2;
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_core_write", 32'(core_write), 32'd0);
    check("rst_core_start", 32'(core_start), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    step();
    check("post_rst_s_ready", 32'(s_ready), 32'd1);

    // Table: each vector through the full frame, vector 0 with cycle-exact latency checks.
    for (int i = 0; i < 5; i++) begin
      core_mode = vecs[i].mode;
      send_frame(vecs[i].in_re, vecs[i].in_im, 8, 1'b0);
      if (i == 0) begin
        for (int j = 0; j <= 5; j++) begin
          check($sformatf("lat_core_write_%0d", j), 32'(core_write), 32'(j == 0));
          check($sformatf("lat_core_start_%0d", j), 32'(core_start), 32'(j >= 1 && j <= 3));
          check($sformatf("lat_m_valid_%0d", j), 32'(m_valid), 32'(j == 5));
          if (j < 5) step();
        end
      end
      collect_frame(vecs[i].ex_re, vecs[i].ex_im, 0, $sformatf("vec%0d", i));
      step();
    end

    // Backpressure.
    core_mode = 1'b0;
    send_frame(vecs[0].in_re, vecs[0].in_im, 8, 1'b0);
    collect_frame(vecs[0].ex_re, vecs[0].ex_im, 1, "bp");
    check("bp_s_ready_after", 32'(s_ready), 32'd1);

    // Flush after 5 samples, then a clean frame.
    begin
      frame_t junk;
      for (int k = 0; k < 8; k++) junk[k] = 16'h5555;
      send_frame(junk, junk, 5, 1'b0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("flush_busy", 32'(busy), 32'd0);
      send_frame(vecs[0].in_re, vecs[0].in_im, 8, 1'b0);
      collect_frame(vecs[0].ex_re, vecs[0].ex_im, 0, "flush5");

      // Flush coincident with a handshake drops that sample.
      send_frame(junk, junk, 3, 1'b0);
      s_valid = 1'b1; s_real = 16'h1234; s_imag = 16'h4321; flush = 1'b1;
      step();
      flush = 1'b0; s_valid = 1'b0;
      send_frame(vecs[3].in_re, vecs[3].in_im, 8, 1'b0);
      collect_frame(vecs[3].ex_re, vecs[3].ex_im, 0, "flush_hs");
    end

    // Back-to-back frames with s_valid held high.
    fork
      begin
        send_frame(vecs[0].in_re, vecs[0].in_im, 8, 1'b1);
        send_frame(vecs[3].in_re, vecs[3].in_im, 8, 1'b0);
      end
      begin
        collect_frame(vecs[0].ex_re, vecs[0].ex_im, 0, "b2b_a");
        collect_frame(vecs[3].ex_re, vecs[3].ex_im, 0, "b2b_b");
      end
    join

    // Asynchronous reset in the middle of RUN.
    send_frame(vecs[0].in_re, vecs[0].in_im, 8, 1'b0);
    step();
    check("pre_rst_core_start", 32'(core_start), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_core_start", 32'(core_start), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_s_ready", 32'(s_ready), 32'd0);
    check("arst_m_valid", 32'(m_valid), 32'd0);
    check("arst_core_in_zero", 32'(core_in_real == '0 && core_in_imag == '0), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    step();
    check("arst_s_ready_next", 32'(s_ready), 32'd1);
    saw_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (m_valid) saw_valid = 1'b1;
      step();
    end
    check("arst_no_m_valid", 32'(saw_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
